// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 one-bit mux: grants one requester at a time,
// drives the mux select and forwards the selected data bit with a valid flag.
module mux8_rr_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] d,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         sel,
    output logic               y,
    output logic               y_valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [7:0]         hold_q, hold_d;

    logic [NUM_REQ-1:0] others;
    logic [2:0]         next_owner;
    logic [2:0]         idle_winner;

    // First set bit of v, scanning start, start+1, ... with wrap from 7 to 0.
    function automatic logic [2:0] pick(input logic [NUM_REQ-1:0] v, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start + 3'(k);
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign others      = req & ~gnt_q;
    assign next_owner  = pick(others, sel_q + 3'd1);
    assign idle_winner = pick(req, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    gnt_d   = NUM_REQ'(1) << idle_winner;
                    sel_d   = idle_winner;
                    hold_d  = 8'd1;
                    state_d = GRANT;
                end
            end
            default: begin
                // Release and tenure expiry both hand over starting just past the owner.
                if (!req[sel_q] || (hold_q >= HOLD_MAX && others != '0)) begin
                    ptr_d = sel_q + 3'd1;
                    if (others != '0) begin
                        gnt_d  = NUM_REQ'(1) << next_owner;
                        sel_d  = next_owner;
                        hold_d = 8'd1;
                    end else begin
                        gnt_d   = '0;
                        sel_d   = 3'd0;
                        hold_d  = 8'd0;
                        state_d = IDLE;
                    end
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = |gnt_q;
    assign y       = y_valid ? d[sel_q] : 1'b0;

endmodule
